// File: rtl/magcomp_pkg.sv
// Shared types and helpers for the serial magnitude-compare accumulator.
package magcomp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      V_EQ = 2'd0,
      V_GT = 2'd1,
      V_LT = 2'd2
   } verdict_t;

   localparam int DIGITS_DEFAULT = 4;

   // True when exactly one of the three digit-compare flags is set.
   function automatic logic onehot3(input logic c0, input logic c1, input logic c2);
      return ({c0, c1, c2} == 3'b100) ||
             ({c0, c1, c2} == 3'b010) ||
             ({c0, c1, c2} == 3'b001);
   endfunction

endpackage

// File: rtl/cmp_digit_merge.sv
// Folds one digit-compare result into the running verdict (MSD first).
// A malformed digit leaves the verdict untouched and raises bad_o.
module cmp_digit_merge
   import magcomp_pkg::*;
(
   input  verdict_t verdict_i,
   input  logic     c0_i,
   input  logic     c1_i,
   input  logic     c2_i,
   output verdict_t verdict_o,
   output logic     bad_o
);

   // Only an EQ verdict can still be decided; GT/LT are locked.
   always_comb begin
      bad_o     = !onehot3(c0_i, c1_i, c2_i);
      verdict_o = verdict_i;
      if (!bad_o && (verdict_i == V_EQ)) begin
         if (c0_i) begin
            verdict_o = V_GT;
         end else if (c2_i) begin
            verdict_o = V_LT;
         end
      end
   end

endmodule

// File: rtl/serial_magcomp_accum.sv
// Accumulates DIGITS per-digit compare results into a wide-compare verdict
// and flags any non-one-hot digit seen during the compare.
module serial_magcomp_accum
   import magcomp_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic in_valid,
   output logic in_ready,
   input  logic c0,
   input  logic c1,
   input  logic c2,
   output logic done,
   output logic gt,
   output logic eq,
   output logic lt,
   output logic err,
   output logic busy
);

   localparam int            CW   = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   state_t        state_q,   state_d;
   logic [CW-1:0] cnt_q,     cnt_d;
   verdict_t      verdict_q, verdict_d;
   logic          err_acc_q, err_acc_d;
   logic          done_q,    done_d;
   logic          gt_q,      gt_d;
   logic          eq_q,      eq_d;
   logic          lt_q,      lt_d;
   logic          err_q,     err_d;

   verdict_t      verdict_merged;
   logic          bad_digit;

   cmp_digit_merge u_merge (
      .verdict_i (verdict_q),
      .c0_i      (c0),
      .c1_i      (c1),
      .c2_i      (c2),
      .verdict_o (verdict_merged),
      .bad_o     (bad_digit)
   );

   // Next-state logic; start overrides everything except reset.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      verdict_d = verdict_q;
      err_acc_d = err_acc_q;
      done_d    = 1'b0;
      gt_d      = gt_q;
      eq_d      = eq_q;
      lt_d      = lt_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         RUN: begin
            if (in_valid && !start) begin
               verdict_d = verdict_merged;
               err_acc_d = err_acc_q | bad_digit;
               if (cnt_q == LAST) begin
                  state_d = DONE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  gt_d    = (verdict_merged == V_GT);
                  eq_d    = (verdict_merged == V_EQ);
                  lt_d    = (verdict_merged == V_LT);
                  err_d   = err_acc_q | bad_digit;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A start in any state (re)opens a compare with everything cleared;
      // an in-flight beat on the same edge is discarded.
      if (start) begin
         state_d   = RUN;
         cnt_d     = '0;
         verdict_d = V_EQ;
         err_acc_d = 1'b0;
         done_d    = 1'b0;
         gt_d      = 1'b0;
         eq_d      = 1'b0;
         lt_d      = 1'b0;
         err_d     = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         verdict_q <= V_EQ;
         err_acc_q <= 1'b0;
         done_q    <= 1'b0;
         gt_q      <= 1'b0;
         eq_q      <= 1'b0;
         lt_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         verdict_q <= verdict_d;
         err_acc_q <= err_acc_d;
         done_q    <= done_d;
         gt_q      <= gt_d;
         eq_q      <= eq_d;
         lt_q      <= lt_d;
         err_q     <= err_d;
      end
   end

   assign in_ready = (state_q == RUN);
   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign gt       = gt_q;
   assign eq       = eq_q;
   assign lt       = lt_q;
   assign err      = err_q;

endmodule

// File: doc/serial_magcomp_accum.md
# serial_magcomp_accum

Sequential stage directly downstream of the 2-bit magnitude comparator. It consumes one 2-bit digit compare result (greater/equal/less) per accepted beat, most-significant digit first. It combines DIGITS beats into the verdict for a 2·DIGITS-bit compare. It also flags malformed (non-one-hot) digit results.

## Interface
- DIGITS, default 4: number of 2-bit digits per compare (8-bit operands at default); legal range 1..16.
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a new compare; honoured in every state.
- in_valid  in  1  digit result present on c0/c1/c2.
- in_ready  out  1  block accepts a digit this cycle.
- c0  in  1  digit a>b.
- c1  in  1  digit a==b.
- c2  in  1  digit a<b.
- done  out  1  one-cycle pulse: verdict final.
- gt  out  1  operand A > operand B.
- eq  out  1  operands equal.
- lt  out  1  operand A < operand B.
- err  out  1  at least one accepted digit was not one-hot.
- busy  out  1  compare in progress (state RUN).

## Operation
- States:
  - IDLE: after reset or after DONE, no start.
  - RUN: digits being accepted.
  - DONE: one cycle.
- IDLE:
  - in_ready=0, busy=0.
  - start → RUN; clear digit counter, verdict←EQ, gt/eq/lt/err←0.
- RUN:
  - in_ready=1, busy=1.
  - A beat is accepted when in_valid=1 in RUN.
  - While verdict=EQ: c0 → GT; c2 → LT; c1 → stay EQ.
  - Once GT or LT, verdict is locked; later digit values are ignored for the verdict but still counted and checked.
  - One-hot check per accepted beat: {c0,c1,c2} not exactly one-hot → err sticky until next start; the verdict does not change on that beat.
  - Counter increments per accepted beat. The beat accepted with counter==DIGITS-1 → DONE.
  - in_valid=0 stalls indefinitely, with no timeout.
- DONE:
  - done=1 for exactly one cycle.
  - gt/eq/lt drive the one-hot verdict; err is final.
  - → IDLE, unless start is high (see below).
- gt/eq/lt/err hold their DONE values through IDLE until the next start clears them. All four are 0 during RUN.
- start in RUN: abort. Counter cleared, verdict←EQ, outputs cleared, stay in RUN; no done for the aborted compare. The current beat is discarded even if in_valid=1.
- start in DONE: done still pulses this cycle with the finished verdict; next state RUN with cleared counter/outputs.
- DIGITS=1: the first accepted beat completes the compare.
- Counter width $clog2(DIGITS+1). Counter never exceeds DIGITS-1 in RUN.

## Timing
- Reset values: state IDLE; in_ready, done, gt, eq, lt, err, busy all 0.
- rst has priority over start and in_valid on the same edge.
- start sampled at edge t → RUN and in_ready=1 from cycle t+1.
- Final digit accepted at edge t → done=1 and verdict valid during cycle t+1.
- Minimum start-to-done: DIGITS+1 edges after the start edge, with in_valid held high.
- All outputs registered; no combinational path from inputs to outputs, except in_ready and busy, which decode state only.
- The upstream comparator is combinational. Its c0/c1/c2 are sampled on the accepting edge with no added latency.

## Structure
- Package magcomp_pkg:
  - state_t enum {IDLE, RUN, DONE};
  - verdict_t enum {V_EQ, V_GT, V_LT};
  - DIGITS_DEFAULT=4;
  - function onehot3(c0,c1,c2).
- One combinational sub-module, cmp_digit_merge:
  - inputs: current verdict_t plus c0/c1/c2;
  - outputs: next verdict_t and a bad-digit flag.
  - Keeps the FSM/counter module focused on sequencing.

## Test plan
- DIGITS=4, beats (c1,c1,c0,c2) back-to-back after start → done 5 cycles after the start edge, gt=1 eq=0 lt=0 err=0.
- Beats (c1,c1,c1,c1) with in_valid low for 3 cycles between beats 2 and 3 → in_ready held, done after the 4th accepted beat, eq=1.
- Beats (c2,c0,c0,c0) → lt=1 (verdict locked on the first digit); outputs hold lt=1 for 10 idle cycles, then clear on the next start.
- Second beat {c0,c1,c2}=110 and third 000, others c1 → err=1 at done, eq=1. A fresh start clears err to 0.
- start reasserted after 2 beats, then 4 beats c0,c1,c1,c1 → exactly one done pulse, gt=1. rst mid-RUN → all outputs 0, in_ready=0 next cycle.
- DIGITS=1, single beat c2 → done one cycle after the accepting edge, lt=1. start asserted in the DONE cycle → done pulses, busy=1 next cycle.
